uart_rx_framed: RTL
===================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit; legal values are even integers 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rstn, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-009 SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-010 SHALL have port data_o, output, DATA_BITS, meaning the received payload, LSB first on the line.
REQ-011 SHALL have port valid_o, output, 1, meaning data_o and the error flags hold an unconsumed frame.
REQ-012 SHALL have port ready_i, input, 1, meaning the consumer accepts the frame when valid_o && ready_i.
REQ-013 SHALL have port parity_err_o, output, 1, meaning the held frame had a parity mismatch; always 0 when PARITY=0.
REQ-014 SHALL have port frame_err_o, output, 1, meaning the held frame had a stop bit sampled low.
REQ-015 SHALL have port overrun_o, output, 1, meaning a one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy_o, output, 1, meaning high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer that resets to 1; all line decisions use the synchronized value rxs.
REQ-018 SHALL generate a tick every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) cycles, with integer truncation and a minimum of 1.
REQ-019 SHALL hold the tick divider cleared in IDLE and restart it on start detection, so tick phase aligns to the start edge.
REQ-020 SHALL implement states IDLE, START, DATA, PAR, STOP and DONE.
REQ-021 SHALL leave IDLE for START on the first cycle rxs=0.
REQ-022 SHALL take each bit value as the majority of rxs at sample ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-023 SHALL return from START to IDLE, with no output activity, when the start-bit majority is 1 (glitch rejection).
REQ-024 SHALL move START -> DATA after OVERSAMPLE ticks, then shift DATA_BITS bits LSB first.
REQ-025 SHALL go DATA -> PAR when PARITY != 0, and DATA -> STOP otherwise.
REQ-026 SHALL set parity error when XOR(data, parity bit) != (PARITY==2).
REQ-027 SHALL sample STOP_BITS stop bits and set frame error if any stop majority is 0.
REQ-028 SHALL enter DONE on the tick after the last stop sample point (mid-bit), without waiting for the bit end.
REQ-029 SHALL, in DONE, load data_o and both error flags, set valid_o in the next cycle, and go to IDLE when valid_o=0 or the frame is accepted that same cycle.
REQ-030 SHALL otherwise, in DONE, drop the new frame, keep the old data and flags, pulse overrun_o for 1 cycle and go to IDLE.
REQ-031 SHALL clear valid_o in the cycle after valid_o && ready_i; data_o and the flags hold their values until the next load.
REQ-032 SHALL treat a low line in IDLE that follows a frame error (break) as a new start; there is no separate break detection.

Reset
REQ-033 SHALL, on rstn low, asynchronously set state IDLE, the synchronizer to 1, data_o 0, valid_o 0, all error flags 0, overrun_o 0, busy_o 0, and all counters 0.
REQ-034 SHALL discard any frame in progress on a reset mid-frame, and SHALL require a fresh falling edge after reset release before receiving.

Structure
REQ-035 SHALL take the state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the majority-vote function from shared package uart_pkg.
REQ-036 SHALL place the tick divider in sub-module uart_os_tick (ports clk, rstn, en, tick; parameter DIV).
REQ-037 SHALL reject illegal parameter values with an elaboration-time assertion.

Verification (all scenarios: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and 160 cycles/bit)
REQ-038 SHALL cover 8N1 byte 0xA5 with ready_i held 1 -> data_o=0xA5, valid_o high for 1 cycle, no error flags.
REQ-039 SHALL cover PARITY=1, byte 0x03 sent with parity bit 1 -> parity_err_o=1, data_o=0x03.
REQ-040 SHALL cover a 40-cycle low glitch on idle rx -> no valid_o, busy_o back to 0 by cycle 100 after the glitch.
REQ-041 SHALL cover two back-to-back frames 0x11 then 0x22 with ready_i=0 -> data_o stays 0x11 and overrun_o pulses once.
REQ-042 SHALL cover stop bit driven 0 on byte 0x7E -> frame_err_o=1; a following 0x55 is received clean.
REQ-043 SHALL cover rstn pulsed low mid-DATA -> all outputs 0 immediately; the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: FSM states, parity modes
// and the 2-of-3 majority vote used for every bit decision.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Consumer-side bundle of the receiver: held frame, its flags and the
// valid/ready handshake. The receiver drives through master, the sink uses slave.
interface uart_rx_framed_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (output data, valid, parity_err, frame_err, overrun, busy,
                  input  ready);
  modport slave  (input  data, valid, parity_err, frame_err, overrun, busy,
                  output ready);
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while en is high.
// Held cleared while en is low so the first tick lands DIV cycles after enable.
module uart_os_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // free-running divider, restarted whenever en drops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             cnt <= '0;
    else if (!en)          cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with majority-voted bits, optional parity,
// 1/2 stop bits and a one-deep valid/ready output holding register.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S_LO   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] S_HI   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_DONE = TW'(OVERSAMPLE/2 + 2);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY == PAR_ODD);

  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || BAUD < 1) begin : g_bad_param
    $error("uart_rx_framed: illegal parameter value");
  end

  rx_state_e            state, state_nx;
  logic                 rx_meta, rxs;
  logic [1:0]           prime;
  logic                 armed;
  logic                 tick;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           votes;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc;
  logic                 sample, decide, maj, perr, load, drop;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (state != IDLE),
    .tick (tick)
  );

  assign sample = tick && (tick_cnt >= S_LO) && (tick_cnt <= S_HI);
  assign decide = tick && (tick_cnt == S_HI);
  assign maj    = maj3({votes, rxs});
  assign perr   = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != ODD);
  assign busy_o = (state != IDLE);

  // 2-flop line synchronizer; arming needs a real high seen after reset
  // so a line held low through reset is not taken as a start edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      prime   <= '0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      prime   <= {prime[0], 1'b1};
      if (prime[1] && rxs) armed <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and DONE-cycle load/drop decision
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE:  if (!rxs && armed) state_nx = START;
      START: if (decide && maj)                        state_nx = IDLE;
             else if (tick && tick_cnt == T_END)       state_nx = DATA;
      DATA:  if (tick && tick_cnt == T_END && bit_cnt == LAST_D)
               state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:   if (tick && tick_cnt == T_END)            state_nx = STOP;
      STOP:  if (tick && tick_cnt == T_DONE && bit_cnt == LAST_S)
               state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        load     = !valid_o || ready_i;
        drop     = valid_o && !ready_i;
      end
      default: state_nx = IDLE;
    endcase
  end

  // bit timing, sampling and frame assembly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      votes    <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == IDLE)  tick_cnt <= '0;
      else if (tick)      tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + TW'(1);
      if (state != state_nx) bit_cnt <= '0;
      else if (tick && tick_cnt == T_END && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 4'd1;
      if (sample) votes <= {votes[0], rxs};
      if (state == DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == PAR && decide)  par_bit <= maj;
      if (state == IDLE)                       ferr_acc <= 1'b0;
      else if (state == STOP && decide && !maj) ferr_acc <= 1'b1;
    end
  end

  // output holding register and overrun pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= drop;
      if (load) begin
        data_o       <= shreg;
        parity_err_o <= perr;
        frame_err_o  <= ferr_acc;
        valid_o      <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule
